// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared memory.
// Fixed-latency accesses, round-robin on conflict, one registered ack per transaction.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic       GRANT_IF = 1'b0;
  localparam logic       GRANT_D  = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic        r_owner;
  logic        r_if_ack;
  logic        r_d_ack;
  logic [15:0] r_if_data;
  logic [15:0] r_d_rdata;
  logic        r_mem_en;
  logic        r_mem_wr;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;

  logic        w_any_req;
  logic        w_grant_d;

  // D wins when it is the only requester, or on a conflict when IF was served last.
  assign w_any_req = if_req | d_req;
  assign w_grant_d = d_req & (~if_req | (r_last_grant == GRANT_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= GRANT_IF;
      r_owner      <= GRANT_IF;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_if_data    <= 16'h0000;
      r_d_rdata    <= 16'h0000;
      r_mem_en     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_mem_wdata  <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_ACCESS;
            r_cnt        <= 4'd0;
            r_last_grant <= w_grant_d;
            r_owner      <= w_grant_d;
            r_mem_en     <= 1'b1;
            r_mem_wr     <= w_grant_d & d_wr;
            r_mem_addr   <= w_grant_d ? d_addr  : if_addr;
            r_mem_wdata  <= w_grant_d ? d_wdata : 16'h0000;
          end
        end

        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          // Final access cycle: capture read data alongside the transition to RESP
          if (r_cnt == LAST_CNT) begin
            r_state  <= S_RESP;
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            if (!r_mem_wr) begin
              if (r_owner == GRANT_D) begin
                r_d_rdata <= mem_rdata;
              end else begin
                r_if_data <= mem_rdata;
              end
            end
            if (r_owner == GRANT_D) begin
              r_d_ack <= 1'b1;
            end else begin
              r_if_ack <= 1'b1;
            end
          end
        end

        S_RESP: begin
          r_state  <= S_IDLE;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
          r_mem_wr <= 1'b0;
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_data   = r_if_data;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, conflict round-robin, store, abort.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_data;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.LATENCY(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_data   (if_data),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 2 ns after the next rising edge; acks must never overlap.
  task automatic step();
    @(posedge clk);
    #2;
    check_eq("ack_excl", 16'(if_ack & d_ack), 16'h0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; if_req = 1'b0; if_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
    #1;
    pulse_reset();
    check_eq("rst_busy",   16'(busy),   16'h0);
    check_eq("rst_mem_en", 16'(mem_en), 16'h0);
    check_eq("rst_addr",   mem_addr,    16'h0000);

    // Single fetch, with if_addr changed during ACCESS
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hA5A5;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) if_addr = 16'hFFFF;
      check_eq($sformatf("fetch_en_c%0d", c),   16'(mem_en), 16'h1);
      check_eq($sformatf("fetch_addr_c%0d", c), mem_addr,    16'h0010);
      check_eq($sformatf("fetch_wr_c%0d", c),   16'(mem_wr), 16'h0);
      check_eq($sformatf("fetch_ack_c%0d", c),  16'(if_ack), 16'h0);
    end
    step();
    check_eq("fetch_ack",  16'(if_ack), 16'h1);
    check_eq("fetch_data", if_data,     16'hA5A5);
    check_eq("fetch_en5",  16'(mem_en), 16'h0);
    check_eq("fetch_busy5",16'(busy),   16'h1);
    if_req = 1'b0;
    step();
    check_eq("fetch_ack6", 16'(if_ack), 16'h0);
    check_eq("fetch_idle", 16'(busy),   16'h0);

    // Conflict from reset: D first, then IF, then D again
    pulse_reset();
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300; mem_rdata = 16'h1111;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq($sformatf("cfl_d_addr_c%0d", c), mem_addr, 16'h0300);
    end
    step();
    check_eq("cfl_d_ack",   16'(d_ack),  16'h1);
    check_eq("cfl_if_ack5", 16'(if_ack), 16'h0);
    check_eq("cfl_d_rdata", d_rdata,     16'h1111);
    d_req = 1'b0; mem_rdata = 16'h2222;
    step();
    check_eq("cfl_idle6",   16'(busy),   16'h0);
    for (int c = 7; c <= 10; c++) begin
      step();
      check_eq($sformatf("cfl_if_addr_c%0d", c), mem_addr,   16'h0100);
      check_eq($sformatf("cfl_if_en_c%0d", c),   16'(mem_en), 16'h1);
    end
    step();
    check_eq("cfl_if_ack",  16'(if_ack), 16'h1);
    check_eq("cfl_if_data", if_data,     16'h2222);
    check_eq("cfl_d_hold",  d_rdata,     16'h1111);
    if_req = 1'b0;
    step();
    check_eq("cfl_idle12",  16'(busy),   16'h0);
    if_req = 1'b1; if_addr = 16'h0104;
    d_req = 1'b1; d_addr = 16'h0304; mem_rdata = 16'h3333;
    for (int c = 13; c <= 16; c++) begin
      step();
      check_eq($sformatf("cfl2_d_addr_c%0d", c), mem_addr, 16'h0304);
    end
    step();
    check_eq("cfl2_d_ack",   16'(d_ack),  16'h1);
    check_eq("cfl2_d_rdata", d_rdata,     16'h3333);
    check_eq("cfl2_if_hold", if_data,     16'h2222);
    d_req = 1'b0;
    for (int c = 18; c <= 22; c++) step();
    step();
    check_eq("cfl2_if_ack",  16'(if_ack), 16'h1);
    check_eq("cfl2_if_data", if_data,     16'h3333);
    if_req = 1'b0;
    step();

    // Store: write strobe and data for 4 cycles, d_rdata untouched
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_rdata = 16'h5A5A;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) d_wdata = 16'hDEAD;
      check_eq($sformatf("st_wr_c%0d", c),    16'(mem_wr), 16'h1);
      check_eq($sformatf("st_wdata_c%0d", c), mem_wdata,   16'h1234);
      check_eq($sformatf("st_addr_c%0d", c),  mem_addr,    16'h0200);
    end
    step();
    check_eq("st_ack",    16'(d_ack),  16'h1);
    check_eq("st_wr5",    16'(mem_wr), 16'h0);
    check_eq("st_rdata",  d_rdata,     16'h3333);
    d_req = 1'b0; d_wr = 1'b0;
    step();

    // Abort: asynchronous reset in ACCESS cycle 2
    if_req = 1'b1; if_addr = 16'h0040; mem_rdata = 16'h6666;
    step();
    step();
    check_eq("ab_en_c2", 16'(mem_en), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ab_mem_en",   16'(mem_en), 16'h0);
    check_eq("ab_mem_wr",   16'(mem_wr), 16'h0);
    check_eq("ab_busy",     16'(busy),   16'h0);
    check_eq("ab_mem_addr", mem_addr,    16'h0000);
    check_eq("ab_wdata",    mem_wdata,   16'h0000);
    check_eq("ab_if_data",  if_data,     16'h0000);
    check_eq("ab_d_rdata",  d_rdata,     16'h0000);
    check_eq("ab_acks",     16'({if_ack, d_ack}), 16'h0);
    if_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_eq($sformatf("ab_noack_c%0d", c), 16'({if_ack, d_ack, busy}), 16'h0);
    end
    if_req = 1'b1; if_addr = 16'h0050; mem_rdata = 16'h7777;
    for (int c = 1; c <= 4; c++) step();
    check_eq("ab_new_ack4", 16'(if_ack), 16'h0);
    step();
    check_eq("ab_new_ack",  16'(if_ack), 16'h1);
    check_eq("ab_new_data", if_data,     16'h7777);
    if_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning memory access cycles per transaction (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  input  16  fetch word address.
REQ-006 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_data  output  16  fetched word, registered.
REQ-008 SHALL have port d_req  input  1  data-access request, held until d_ack.
REQ-009 SHALL have port d_wr  input  1  1 = store, 0 = load.
REQ-010 SHALL have port d_addr  input  16  data word address.
REQ-011 SHALL have port d_wdata  input  16  store data.
REQ-012 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port d_rdata  output  16  loaded word, registered.
REQ-014 SHALL have port mem_en  output  1  shared memory enable.
REQ-015 SHALL have port mem_wr  output  1  shared memory write strobe.
REQ-016 SHALL have port mem_addr  output  16  shared memory address.
REQ-017 SHALL have port mem_wdata  output  16  shared memory write data.
REQ-018 SHALL have port mem_rdata  input  16  shared memory read data.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP, plus a 4-bit cycle counter cnt and a 1-bit last_grant register (IF or D).
REQ-021 IDLE: no request -> stay; exactly one request -> grant it; both -> grant the requester not equal to last_grant; on grant, go to ACCESS, cnt=0, last_grant=winner.
REQ-022 SHALL capture the winner's address, d_wr (0 for fetch), and d_wdata into mem_addr/mem_wr/mem_wdata registers at the grant edge; requester input changes after grant SHALL not affect them.
REQ-023 ACCESS: mem_en=1 and mem_wr=captured write bit for exactly LATENCY cycles; cnt increments each cycle.
REQ-024 In the ACCESS cycle where cnt==LATENCY-1, a read SHALL load mem_rdata into if_data (fetch) or d_rdata (load) at that edge; next state RESP.
REQ-025 RESP: mem_en=0, mem_wr=0; winner's ack=1 for exactly one cycle; next state IDLE.
REQ-026 Latency: request high in IDLE cycle N -> mem_en high cycles N+1..N+LATENCY -> ack in cycle N+LATENCY+1; minimum issue interval LATENCY+2 cycles.
REQ-027 Requesters drop req at the edge ending their ack cycle; req high in the following IDLE cycle is a new request.
REQ-028 Stores SHALL leave d_rdata unchanged; if_data/d_rdata hold their value until the next capture.
REQ-029 Requests arriving while not IDLE SHALL wait; no request is dropped and at most one ack is asserted per cycle.
REQ-030 if_ack and d_ack SHALL never both be high.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, cnt=0, last_grant=IF, and all outputs to 0 (mem_addr, mem_wdata, if_data, d_rdata = 0x0000), independent of clk.
REQ-032 Reset during ACCESS or RESP SHALL abort the transaction; no ack is issued for it after release.
REQ-033 First edge after rst_n deasserts SHALL be treated as a normal IDLE cycle.

Verification
REQ-034 Reset: rst_n=0 mid-cycle, LATENCY=4 -> all outputs 0 and busy=0 before the next clk edge.
REQ-035 Single fetch: if_req=1, if_addr=0x0010 in cycle 0, mem_rdata=0xA5A5 -> mem_en=1, mem_addr=0x0010 in cycles 1-4; if_ack=1 in cycle 5 with if_data=0xA5A5.
REQ-036 Conflict: if_req and d_req both high from reset -> D served first (d_ack in cycle 5), fetch granted in cycle 6 (if_ack in cycle 11); a repeated conflict is again won by D.
REQ-037 Store: d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_wr=1, mem_wdata=0x1234 for 4 cycles; d_ack in cycle 5; d_rdata unchanged.
REQ-038 Input stability: change if_addr to 0xFFFF in cycle 2 of ACCESS -> mem_addr stays 0x0010 through cycle 4.
REQ-039 Abort: rst_n pulsed low in ACCESS cycle 2 -> mem_en drops at once, no ack follows; a new fetch after release completes in LATENCY+1 cycles.
